// File: rtl/pong_ball_engine.sv
// pong_ball_engine
// Ball physics and scoring engine for the Pong video path. Holds ball position
// and velocity, advances once per FRAME_DIV frames at end-of-frame, resolves
// goals, zoned paddle deflection and wall bounces, sequences serve/play/over,
// and produces the registered ball pixel flag for the colour mux.
module pong_ball_engine #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BALL_SIZE    = 8,
    parameter int PAD_W        = 10,
    parameter int PAD_H        = 90,
    parameter int PAD1_X       = 10,
    parameter int PAD2_X       = 620,
    parameter int SPEED_X      = 2,
    parameter int MAX_DY       = 3,
    parameter int FRAME_DIV    = 1,
    parameter int SERVE_FRAMES = 60,
    parameter int SCORE_W      = 2,
    parameter int WIN_SCORE    = 3
) (
    input  logic               clk_in,
    input  logic               i_rst_n,
    input  logic               enablePong,
    input  logic               restart,
    input  logic               o_active,
    input  logic [9:0]         o_x,
    input  logic [8:0]         o_y,
    input  logic [8:0]         pos_yBarra1,
    input  logic [8:0]         pos_yBarra2,
    input  logic [3:0]         rnd,
    output logic               color,
    output logic [9:0]         ball_x,
    output logic [8:0]         ball_y,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         point_evt,
    output logic               game_over,
    output logic [1:0]         state
);

    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int SRV_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    // Ball home position (top-left corner of the centred ball)
    localparam logic [9:0] CX = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [8:0] CY = 9'((V_RES - BALL_SIZE) / 2);

    // Physics constants in the 12-bit signed working domain
    localparam logic signed [11:0] X_MAX   = 12'(H_RES - BALL_SIZE);
    localparam logic signed [11:0] Y_MAX   = 12'(V_RES - BALL_SIZE);
    localparam logic signed [11:0] SPD     = 12'(SPEED_X);
    localparam logic signed [11:0] GOAL_R  = 12'(H_RES - BALL_SIZE - SPEED_X);
    localparam logic signed [11:0] BSZ     = 12'(BALL_SIZE);
    localparam logic signed [11:0] BHALF   = 12'(BALL_SIZE / 2);
    localparam logic signed [11:0] PADH    = 12'(PAD_H);
    localparam logic signed [11:0] ZONE_LO = 12'(PAD_H / 3);
    localparam logic signed [11:0] ZONE_HI = 12'((2 * PAD_H) / 3);
    localparam logic signed [11:0] P1_L    = 12'(PAD1_X);
    localparam logic signed [11:0] P1_R    = 12'(PAD1_X + PAD_W);
    localparam logic signed [11:0] P2_L    = 12'(PAD2_X);
    localparam logic signed [11:0] P2_R    = 12'(PAD2_X + PAD_W);
    localparam logic signed [3:0]  MDY     = 4'(MAX_DY);

    localparam logic [10:0]        BSZ11    = 11'(BALL_SIZE);
    localparam logic [SCORE_W-1:0] LAST_PT  = SCORE_W'(WIN_SCORE - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(FRAME_DIV - 1);
    localparam logic [SRV_W-1:0]   SRV_LAST = SRV_W'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    state_t                    st;
    logic                      dx_neg;   // horizontal speed is always +/-SPEED_X
    logic signed [3:0]         dy;
    logic [DIV_W-1:0]          div_cnt;
    logic [SRV_W-1:0]          srv_cnt;

    logic                      frame_end;
    logic                      step;
    logic signed [11:0]        sx, sy, sdx, sdy;
    logic signed [11:0]        pad1, pad2;
    logic signed [11:0]        nx_raw, nx, ny;
    logic                      goal_l, goal_r, hit1, hit2, wall_top, wall_bot;
    logic signed [3:0]         dy_pad1, dy_pad2;
    logic [10:0]               px, py, bx_end, by_end;
    logic                      pix_in_ball;
    logic                      spare_unused;

    // Deflection from the paddle zone struck by the ball centre
    function automatic logic signed [3:0] zone_dy(input logic signed [11:0] c,
                                                  input logic signed [3:0]  cur,
                                                  input logic               flip);
        logic neg;
        neg = cur[3] ^ flip;
        if (c < ZONE_LO)
            return -MDY;
        if (c >= ZONE_HI)
            return MDY;
        return neg ? -4'sd1 : 4'sd1;
    endfunction

    assign state = st;

    // Upper random bits are reserved; truncated arithmetic bits are known zero
    assign spare_unused = ^{rnd[3:2], nx[11:10], ny[11:9]};

    // Frame timing: end-of-frame strobe and physics step qualifier
    always_comb begin
        frame_end = (o_x == 10'(H_RES - 1)) && (o_y == 9'(V_RES - 1)) && enablePong;
        step      = frame_end && (div_cnt == DIV_LAST);
    end

    // Collision and motion decisions evaluated on the current ball state
    always_comb begin
        sx   = $signed({2'b00, ball_x});
        sy   = $signed({3'b000, ball_y});
        sdx  = dx_neg ? -SPD : SPD;
        sdy  = {{8{dy[3]}}, dy};
        pad1 = $signed({3'b000, pos_yBarra1});
        pad2 = $signed({3'b000, pos_yBarra2});

        goal_l = dx_neg && (sx <= SPD);
        goal_r = !dx_neg && (sx >= GOAL_R);

        hit1 = dx_neg && (sx >= P1_L) && (sx <= P1_R)
               && (sy + BSZ > pad1) && (sy < pad1 + PADH);
        hit2 = !dx_neg && (sx + BSZ >= P2_L) && (sx + BSZ <= P2_R)
               && (sy + BSZ > pad2) && (sy < pad2 + PADH);

        dy_pad1 = zone_dy(sy + BHALF - pad1, dy, rnd[1]);
        dy_pad2 = zone_dy(sy + BHALF - pad2, dy, rnd[1]);

        ny       = sy + sdy;
        wall_top = (ny < 12'sd0);
        wall_bot = (ny > Y_MAX);

        nx_raw = sx + sdx;
        nx     = nx_raw;
        if (nx_raw < 12'sd0)
            nx = 12'sd0;
        else if (nx_raw > X_MAX)
            nx = X_MAX;
    end

    // Game FSM with ball, velocity, score and event registers
    always_ff @(posedge clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st        <= ST_SERVE;
            ball_x    <= CX;
            ball_y    <= CY;
            dx_neg    <= 1'b0;
            dy        <= 4'sd1;
            score1    <= '0;
            score2    <= '0;
            point_evt <= '0;
            game_over <= 1'b0;
            div_cnt   <= '0;
            srv_cnt   <= '0;
        end else begin
            point_evt <= '0;
            if (enablePong) begin
                if (frame_end)
                    div_cnt <= step ? '0 : div_cnt + DIV_W'(1);

                unique case (st)
                    ST_SERVE: begin
                        if (frame_end) begin
                            if (srv_cnt == SRV_LAST) begin
                                st      <= ST_PLAY;
                                srv_cnt <= '0;
                                dy      <= rnd[0] ? -4'sd1 : 4'sd1;
                            end else begin
                                srv_cnt <= srv_cnt + SRV_W'(1);
                            end
                        end
                    end

                    ST_PLAY: begin
                        if (step) begin
                            if (goal_l) begin
                                score2    <= score2 + SCORE_W'(1);
                                point_evt <= 2'b01;
                                dx_neg    <= 1'b1;
                                ball_x    <= CX;
                                ball_y    <= CY;
                                st        <= (score2 == LAST_PT) ? ST_OVER : ST_SERVE;
                                game_over <= (score2 == LAST_PT);
                            end else if (goal_r) begin
                                score1    <= score1 + SCORE_W'(1);
                                point_evt <= 2'b10;
                                dx_neg    <= 1'b0;
                                ball_x    <= CX;
                                ball_y    <= CY;
                                st        <= (score1 == LAST_PT) ? ST_OVER : ST_SERVE;
                                game_over <= (score1 == LAST_PT);
                            end else if (hit1) begin
                                dx_neg <= 1'b0;
                                dy     <= dy_pad1;
                            end else if (hit2) begin
                                dx_neg <= 1'b1;
                                dy     <= dy_pad2;
                            end else if (wall_top) begin
                                ball_y <= '0;
                                dy     <= -dy;
                            end else if (wall_bot) begin
                                ball_y <= Y_MAX[8:0];
                                dy     <= -dy;
                            end else begin
                                ball_x <= nx[9:0];
                                ball_y <= ny[8:0];
                            end
                        end
                    end

                    ST_OVER: begin
                        if (restart) begin
                            score1    <= '0;
                            score2    <= '0;
                            dx_neg    <= 1'b0;
                            game_over <= 1'b0;
                            st        <= ST_SERVE;
                        end
                    end

                    default: st <= ST_SERVE;
                endcase
            end
        end
    end

    // Pixel-in-ball test against the current scan position
    always_comb begin
        px          = {1'b0, o_x};
        py          = {2'b00, o_y};
        bx_end      = {1'b0, ball_x} + BSZ11;
        by_end      = {2'b00, ball_y} + BSZ11;
        pix_in_ball = (px >= {1'b0, ball_x}) && (px < bx_end)
                      && (py >= {2'b00, ball_y}) && (py < by_end);
    end

    // Registered ball pixel flag for the colour mux
    always_ff @(posedge clk_in or negedge i_rst_n) begin
        if (!i_rst_n)
            color <= 1'b0;
        else
            color <= o_active && enablePong && pix_in_ball;
    end

endmodule

// File: tb/tb_pong_ball_engine.sv
// tb_pong_ball_engine
// Randomized game play checked against a rule-level model of the ball engine.
module tb_pong_ball_engine;

    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int BALL_SIZE    = 8;
    localparam int PAD_W        = 10;
    localparam int PAD_H        = 90;
    localparam int PAD1_X       = 10;
    localparam int PAD2_X       = 620;
    localparam int SPEED_X      = 2;
    localparam int MAX_DY       = 3;
    localparam int FRAME_DIV    = 1;
    localparam int SERVE_FRAMES = 4;
    localparam int SCORE_W      = 2;
    localparam int WIN_SCORE    = 3;

    localparam int S_SERVE = 0;
    localparam int S_PLAY  = 1;
    localparam int S_OVER  = 2;
    localparam int MAX_GAME_FRAMES = 6000;

    logic               clk_in = 1'b0;
    logic               i_rst_n;
    logic               enablePong;
    logic               restart;
    logic               o_active;
    logic [9:0]         o_x;
    logic [8:0]         o_y;
    logic [8:0]         pos_yBarra1;
    logic [8:0]         pos_yBarra2;
    logic [3:0]         rnd;
    logic               color;
    logic [9:0]         ball_x;
    logic [8:0]         ball_y;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic [1:0]         point_evt;
    logic               game_over;
    logic [1:0]         state;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_state, m_x, m_y, m_dx, m_dy, m_s1, m_s2, m_cnt, m_div, m_evt;
    bit miss_plan;

    always #5 clk_in = ~clk_in;

    pong_ball_engine #(
        .H_RES(H_RES), .V_RES(V_RES), .BALL_SIZE(BALL_SIZE), .PAD_W(PAD_W),
        .PAD_H(PAD_H), .PAD1_X(PAD1_X), .PAD2_X(PAD2_X), .SPEED_X(SPEED_X),
        .MAX_DY(MAX_DY), .FRAME_DIV(FRAME_DIV), .SERVE_FRAMES(SERVE_FRAMES),
        .SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE)
    ) dut (
        .clk_in(clk_in), .i_rst_n(i_rst_n), .enablePong(enablePong),
        .restart(restart), .o_active(o_active), .o_x(o_x), .o_y(o_y),
        .pos_yBarra1(pos_yBarra1), .pos_yBarra2(pos_yBarra2), .rnd(rnd),
        .color(color), .ball_x(ball_x), .ball_y(ball_y), .score1(score1),
        .score2(score2), .point_evt(point_evt), .game_over(game_over),
        .state(state)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic new_plan();
        miss_plan = ($urandom_range(0, 1) == 0);
    endtask

    task automatic model_reset();
        m_state = S_SERVE;
        m_x     = (H_RES - BALL_SIZE) / 2;
        m_y     = (V_RES - BALL_SIZE) / 2;
        m_dx    = SPEED_X;
        m_dy    = 1;
        m_s1    = 0;
        m_s2    = 0;
        m_cnt   = 0;
        m_div   = 0;
        m_evt   = 0;
        new_plan();
    endtask

    function automatic bit overlaps(int y, int pad);
        return (y + BALL_SIZE > pad) && (y < pad + PAD_H);
    endfunction

    function automatic int zone_dy(int y, int pad, int cur_dy, bit flip);
        int c = y + BALL_SIZE / 2 - pad;
        if (c < PAD_H / 3)
            return -MAX_DY;
        if (c >= (2 * PAD_H) / 3)
            return MAX_DY;
        return ((cur_dy < 0) != flip) ? -1 : 1;
    endfunction

    task automatic score_point(int player);
        if (player == 1) begin
            m_s1++;
            m_evt = 2;
            m_dx  = SPEED_X;
        end else begin
            m_s2++;
            m_evt = 1;
            m_dx  = -SPEED_X;
        end
        m_x = (H_RES - BALL_SIZE) / 2;
        m_y = (V_RES - BALL_SIZE) / 2;
        m_state = (m_s1 == WIN_SCORE || m_s2 == WIN_SCORE) ? S_OVER : S_SERVE;
        new_plan();
    endtask

    // Game rules applied at one end-of-frame, using the inputs about to be sampled
    task automatic model_frame_end();
        bit step;
        int ny;
        m_evt = 0;
        if (!enablePong)
            return;
        step  = (m_div == FRAME_DIV - 1);
        m_div = step ? 0 : m_div + 1;
        if (m_state == S_SERVE) begin
            if (m_cnt == SERVE_FRAMES - 1) begin
                m_state = S_PLAY;
                m_cnt   = 0;
                m_dy    = rnd[0] ? -1 : 1;
            end else begin
                m_cnt++;
            end
        end else if (m_state == S_PLAY && step) begin
            if (m_dx < 0 && m_x <= SPEED_X) begin
                score_point(2);
            end else if (m_dx > 0 && m_x >= H_RES - BALL_SIZE - SPEED_X) begin
                score_point(1);
            end else if (m_dx < 0 && m_x >= PAD1_X && m_x <= PAD1_X + PAD_W
                         && overlaps(m_y, int'(pos_yBarra1))) begin
                m_dx = SPEED_X;
                m_dy = zone_dy(m_y, int'(pos_yBarra1), m_dy, rnd[1]);
                new_plan();
            end else if (m_dx > 0 && m_x + BALL_SIZE >= PAD2_X
                         && m_x + BALL_SIZE <= PAD2_X + PAD_W
                         && overlaps(m_y, int'(pos_yBarra2))) begin
                m_dx = -SPEED_X;
                m_dy = zone_dy(m_y, int'(pos_yBarra2), m_dy, rnd[1]);
                new_plan();
            end else begin
                ny = m_y + m_dy;
                if (ny < 0) begin
                    m_y  = 0;
                    m_dy = -m_dy;
                end else if (ny > V_RES - BALL_SIZE) begin
                    m_y  = V_RES - BALL_SIZE;
                    m_dy = -m_dy;
                end else begin
                    m_x = m_x + m_dx;
                    if (m_x < 0) m_x = 0;
                    if (m_x > H_RES - BALL_SIZE) m_x = H_RES - BALL_SIZE;
                    m_y = ny;
                end
            end
        end
    endtask

    task automatic model_restart();
        m_evt = 0;
        if (enablePong && m_state == S_OVER) begin
            m_s1    = 0;
            m_s2    = 0;
            m_dx    = SPEED_X;
            m_state = S_SERVE;
        end
    endtask

    // Approaching paddle either lines up with the ball (random zone) or sits far away
    task automatic plan_paddles();
        int p;
        if (miss_plan)
            p = (m_y < V_RES / 2 - 40) ? V_RES - PAD_H : 0;
        else
            p = m_y + BALL_SIZE / 2 - int'($urandom_range(0, PAD_H - 1));
        if (p < 0) p = 0;
        if (p > 511) p = 511;
        if (m_dx < 0) begin
            pos_yBarra1 = 9'(p);
            pos_yBarra2 = 9'($urandom_range(0, V_RES - PAD_H));
        end else begin
            pos_yBarra2 = 9'(p);
            pos_yBarra1 = 9'($urandom_range(0, V_RES - PAD_H));
        end
    endtask

    task automatic drive_frame_end();
        plan_paddles();
        rnd      = 4'($urandom);
        o_x      = 10'(H_RES - 1);
        o_y      = 9'(V_RES - 1);
        o_active = 1'b0;
        model_frame_end();
        tick();
    endtask

    // One scan pixel near (or on) the ball; returns the flag expected next cycle
    task automatic drive_probe(input bit on_ball, output bit exp_col);
        int px, py;
        if (on_ball) begin
            px       = m_x + int'($urandom_range(0, BALL_SIZE - 1));
            py       = m_y + int'($urandom_range(0, BALL_SIZE - 1));
            o_active = 1'b1;
        end else begin
            px       = m_x + int'($urandom_range(0, BALL_SIZE + 5)) - 3;
            py       = m_y + int'($urandom_range(0, BALL_SIZE + 5)) - 3;
            o_active = ($urandom_range(0, 3) != 0);
        end
        if (px < 0) px = 0;
        if (px > H_RES - 1) px = H_RES - 1;
        if (py < 0) py = 0;
        if (py > V_RES - 1) py = V_RES - 1;
        if (px == H_RES - 1 && py == V_RES - 1) py = V_RES - 2;
        o_x = 10'(px);
        o_y = 9'(py);
        exp_col = o_active && enablePong && px >= m_x && px < m_x + BALL_SIZE
                  && py >= m_y && py < m_y + BALL_SIZE;
        m_evt = 0;
        tick();
        o_active = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n     = 1'b0;
        enablePong  = 1'b0;
        restart     = 1'b0;
        o_active    = 1'b0;
        o_x         = '0;
        o_y         = '0;
        pos_yBarra1 = '0;
        pos_yBarra2 = '0;
        rnd         = '0;
        model_reset();
        tick();
        tick();
        n_tests += 8;
        if (ball_x !== 10'd316) begin n_fail++; $display("FAIL reset_ball_x: got %0d want 316", ball_x); end
        if (ball_y !== 9'd236) begin n_fail++; $display("FAIL reset_ball_y: got %0d want 236", ball_y); end
        if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        if (score1 !== '0) begin n_fail++; $display("FAIL reset_score1: got %0d want 0", score1); end
        if (score2 !== '0) begin n_fail++; $display("FAIL reset_score2: got %0d want 0", score2); end
        if (point_evt !== 2'b00) begin n_fail++; $display("FAIL reset_point_evt: got %b want 00", point_evt); end
        if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over: got %b want 0", game_over); end
        if (color !== 1'b0) begin n_fail++; $display("FAIL reset_color: got %b want 0", color); end
        i_rst_n = 1'b1;
        tick();
    endtask

    // Serve countdown, including frames with the engine disabled in between
    task automatic test_serve();
        bit exp_col;
        enablePong = 1'b1;
        for (int f = 1; f <= 5; f++) begin
            if (f == 3) begin
                enablePong = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    drive_frame_end();
                    n_tests++;
                    if (state !== 2'd0) begin n_fail++; $display("FAIL serve_frozen_state: got %0d want 0", state); end
                    drive_probe(1'b1, exp_col);
                    n_tests++;
                    if (color !== 1'b0) begin n_fail++; $display("FAIL serve_frozen_color: got %b want 0", color); end
                end
                enablePong = 1'b1;
            end
            drive_frame_end();
            n_tests += 3;
            if (state !== 2'(m_state)) begin n_fail++; $display("FAIL serve_state f%0d: got %0d want %0d", f, state, m_state); end
            if (ball_x !== 10'(m_x)) begin n_fail++; $display("FAIL serve_ball_x f%0d: got %0d want %0d", f, ball_x, m_x); end
            if (ball_y !== 9'(m_y)) begin n_fail++; $display("FAIL serve_ball_y f%0d: got %0d want %0d", f, ball_y, m_y); end
            if (f < 4) begin
                n_tests++;
                if (state !== 2'd0) begin n_fail++; $display("FAIL serve_hold f%0d: got state %0d want 0", f, state); end
            end
            if (f == 4) begin
                n_tests++;
                if (state !== 2'd1) begin n_fail++; $display("FAIL serve_to_play: got state %0d want 1", state); end
            end
            if (f == 5) begin
                n_tests++;
                if (ball_x !== 10'd318) begin n_fail++; $display("FAIL first_step_x: got %0d want 318", ball_x); end
            end
        end
    endtask

    // Disable mid-play: everything frozen, colour forced low; restart ignored in play
    task automatic test_enable_freeze();
        bit exp_col;
        int hold_x, hold_y;
        for (int f = 0; f < 10; f++) drive_frame_end();
        hold_x = m_x;
        hold_y = m_y;
        enablePong = 1'b0;
        for (int f = 0; f < 5; f++) begin
            drive_frame_end();
            n_tests += 3;
            if (ball_x !== 10'(hold_x)) begin n_fail++; $display("FAIL freeze_ball_x: got %0d want %0d", ball_x, hold_x); end
            if (ball_y !== 9'(hold_y)) begin n_fail++; $display("FAIL freeze_ball_y: got %0d want %0d", ball_y, hold_y); end
            if (state !== 2'd1) begin n_fail++; $display("FAIL freeze_state: got %0d want 1", state); end
            drive_probe(1'b1, exp_col);
            n_tests++;
            if (color !== 1'b0) begin n_fail++; $display("FAIL freeze_color: got %b want 0", color); end
        end
        enablePong = 1'b1;
        o_x = '0;
        o_y = '0;
        restart = 1'b1;
        model_restart();
        tick();
        restart = 1'b0;
        n_tests += 2;
        if (state !== 2'd1) begin n_fail++; $display("FAIL restart_in_play: got state %0d want 1", state); end
        if (ball_x !== 10'(hold_x)) begin n_fail++; $display("FAIL restart_in_play_x: got %0d want %0d", ball_x, hold_x); end
        drive_frame_end();
        n_tests++;
        if (ball_x !== 10'(m_x)) begin n_fail++; $display("FAIL resume_ball_x: got %0d want %0d", ball_x, m_x); end
    endtask

    // Full game with randomized paddles and random bits until someone wins
    task automatic test_rally();
        bit exp_col;
        int frames = 0;
        while (m_state != S_OVER && frames < MAX_GAME_FRAMES) begin
            drive_frame_end();
            frames++;
            n_tests += 7;
            if (ball_x !== 10'(m_x)) begin n_fail++; $display("FAIL rally_ball_x fr%0d: got %0d want %0d", frames, ball_x, m_x); end
            if (ball_y !== 9'(m_y)) begin n_fail++; $display("FAIL rally_ball_y fr%0d: got %0d want %0d", frames, ball_y, m_y); end
            if (state !== 2'(m_state)) begin n_fail++; $display("FAIL rally_state fr%0d: got %0d want %0d", frames, state, m_state); end
            if (score1 !== SCORE_W'(m_s1)) begin n_fail++; $display("FAIL rally_score1 fr%0d: got %0d want %0d", frames, score1, m_s1); end
            if (score2 !== SCORE_W'(m_s2)) begin n_fail++; $display("FAIL rally_score2 fr%0d: got %0d want %0d", frames, score2, m_s2); end
            if (point_evt !== 2'(m_evt)) begin n_fail++; $display("FAIL rally_point_evt fr%0d: got %b want %0d", frames, point_evt, m_evt); end
            if (game_over !== (m_state == S_OVER)) begin n_fail++; $display("FAIL rally_game_over fr%0d: got %b want %0d", frames, game_over, m_state == S_OVER); end
            drive_probe(1'b0, exp_col);
            n_tests += 2;
            if (color !== exp_col) begin n_fail++; $display("FAIL rally_color fr%0d: got %b want %b", frames, color, exp_col); end
            if (point_evt !== 2'b00) begin n_fail++; $display("FAIL rally_evt_pulse fr%0d: got %b want 00", frames, point_evt); end
        end
        n_tests += 2;
        if (state !== 2'd2) begin n_fail++; $display("FAIL rally_reach_over: got state %0d want 2 after %0d frames", state, frames); end
        if (game_over !== 1'b1) begin n_fail++; $display("FAIL rally_over_flag: got %b want 1", game_over); end
    endtask

    // Game over holds the ball at centre until restart clears scores
    task automatic test_restart();
        for (int f = 0; f < 3; f++) begin
            drive_frame_end();
            n_tests += 3;
            if (ball_x !== 10'd316) begin n_fail++; $display("FAIL over_ball_x: got %0d want 316", ball_x); end
            if (ball_y !== 9'd236) begin n_fail++; $display("FAIL over_ball_y: got %0d want 236", ball_y); end
            if (state !== 2'd2) begin n_fail++; $display("FAIL over_state: got %0d want 2", state); end
        end
        o_x = '0;
        o_y = '0;
        restart = 1'b1;
        model_restart();
        tick();
        restart = 1'b0;
        n_tests += 4;
        if (state !== 2'd0) begin n_fail++; $display("FAIL restart_state: got %0d want 0", state); end
        if (score1 !== '0) begin n_fail++; $display("FAIL restart_score1: got %0d want 0", score1); end
        if (score2 !== '0) begin n_fail++; $display("FAIL restart_score2: got %0d want 0", score2); end
        if (game_over !== 1'b0) begin n_fail++; $display("FAIL restart_game_over: got %b want 0", game_over); end
    endtask

    // A second game straight after restart, then another restart
    task automatic test_back_to_back();
        test_rally();
        test_restart();
    endtask

    // Reset asserted away from any clock edge must clear outputs immediately
    task automatic test_async_reset();
        for (int f = 0; f < 12; f++) drive_frame_end();
        n_tests++;
        if (ball_x !== 10'(m_x)) begin n_fail++; $display("FAIL pre_reset_ball_x: got %0d want %0d", ball_x, m_x); end
        #2;
        i_rst_n = 1'b0;
        #1;
        n_tests += 7;
        if (ball_x !== 10'd316) begin n_fail++; $display("FAIL async_ball_x: got %0d want 316", ball_x); end
        if (ball_y !== 9'd236) begin n_fail++; $display("FAIL async_ball_y: got %0d want 236", ball_y); end
        if (state !== 2'd0) begin n_fail++; $display("FAIL async_state: got %0d want 0", state); end
        if (score1 !== '0 || score2 !== '0) begin n_fail++; $display("FAIL async_scores: got %0d/%0d want 0/0", score1, score2); end
        if (point_evt !== 2'b00) begin n_fail++; $display("FAIL async_point_evt: got %b want 00", point_evt); end
        if (game_over !== 1'b0) begin n_fail++; $display("FAIL async_game_over: got %b want 0", game_over); end
        if (color !== 1'b0) begin n_fail++; $display("FAIL async_color: got %b want 0", color); end
        model_reset();
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_serve();
        test_enable_freeze();
        test_rally();
        test_restart();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_ball_engine.md
Name: pong_ball_engine

Overview:
Parametrised ball-physics and scoring engine for the Pong video path, the next generation of the fixed 640x480 ball printer. Holds ball position and signed velocity, steps once per N frames at end-of-frame, and handles wall bounces, zoned paddle deflection, goals, serve delay and game-over. Generates the registered ball pixel flag for the colour mux and exposes score and event outputs to the game controller.

Parameters:
H_RES, 640, active pixels per line
V_RES, 480, active lines per frame
BALL_SIZE, 8, ball edge in pixels (square)
PAD_W, 10, paddle width
PAD_H, 90, paddle height (split into three equal zones)
PAD1_X, 10, left paddle x origin
PAD2_X, 620, right paddle x origin
SPEED_X, 2, horizontal pixels per step
MAX_DY, 3, vertical speed magnitude for edge zones (1..7)
FRAME_DIV, 1, frames per physics step (>=1)
SERVE_FRAMES, 60, frames held at centre before play
SCORE_W, 2, score counter width
WIN_SCORE, 3, score ending the game (< 2**SCORE_W)

Ports:
clk_in  in  1  pixel clock
i_rst_n  in  1  asynchronous active-low reset
enablePong  in  1  engine enable; low freezes all state
restart  in  1  one-cycle pulse; leaves OVER
o_active  in  1  pixel in active area
o_x  in  10  current pixel x
o_y  in  9  current pixel y
pos_yBarra1  in  9  left paddle top y
pos_yBarra2  in  9  right paddle top y
rnd  in  4  free-running random bits (LFSR)
color  out  1  ball pixel flag, registered
ball_x  out  10  ball left x
ball_y  out  9  ball top y
score1  out  SCORE_W  left player score
score2  out  SCORE_W  right player score
point_evt  out  2  one-cycle pulse: [1]=P1 scored, [0]=P2 scored
game_over  out  1  high in OVER
state  out  2  SERVE=0, PLAY=1, OVER=2

Behaviour:
- Reset (async, i_rst_n=0): state=SERVE, ball at centre (cx=(H_RES-BALL_SIZE)/2=316, cy=(V_RES-BALL_SIZE)/2=236), dx=+SPEED_X, dy=+1, scores 0, color 0, point_evt 0, game_over 0, all counters 0.
- frame_end = o_x==H_RES-1 && o_y==V_RES-1 && enablePong; step = frame_end when frame divider at FRAME_DIV-1 (divider then wraps to 0). enablePong low: no state change; color forced 0.
- SERVE: ball held at centre; serve counter increments per frame_end; at SERVE_FRAMES-1 -> PLAY, counter cleared; dy = rnd[0] ? -1 : +1 latched on that transition.
- PLAY, per step, evaluated on current x,y, in priority order:
  1. Left goal: dx<0 and x<=SPEED_X -> score2+1, point_evt[0] pulse, dx=-SPEED_X (serve toward conceding side).
  2. Right goal: dx>0 and x>=H_RES-BALL_SIZE-SPEED_X -> score1+1, point_evt[1] pulse, dx=+SPEED_X.
  3. Paddle hit: dx<0 with x in [PAD1_X, PAD1_X+PAD_W] and y-range overlap of pos_yBarra1 (y+BALL_SIZE>pad_y && y<pad_y+PAD_H) -> dx=+SPEED_X; mirror rule for PAD2 (x+BALL_SIZE in [PAD2_X, PAD2_X+PAD_W], dx>0) -> dx=-SPEED_X. Zone uses ball centre offset c=y+BALL_SIZE/2-pad_y: c<PAD_H/3 -> dy=-MAX_DY; c>=2*PAD_H/3 -> dy=+MAX_DY; else dy=sign(dy)*1, sign flipped when rnd[1]=1.
  4. Walls: next y<0 -> y=0, dy=-dy; next y>V_RES-BALL_SIZE -> clamp to V_RES-BALL_SIZE, dy=-dy.
  5. Otherwise x+=dx, y+=dy. Arithmetic in 12-bit signed; results clamped to legal ranges, no wrap.
- After a goal: ball to centre; new score==WIN_SCORE -> OVER, else SERVE. Scores never exceed WIN_SCORE.
- Simultaneous goal and paddle conditions: goal wins.
- OVER: ball frozen at centre, game_over=1; restart pulse clears scores -> SERVE, dx=+SPEED_X. restart ignored outside OVER.
- color: 1-cycle latency; color<=o_active && enablePong && x<=o_x<x+BALL_SIZE && y<=o_y<y+BALL_SIZE, else 0 (no latch).
- ball_x/ball_y/score/state are registered copies of internal state (update same edge as step).

Test Plan:
- Reset, enable, SERVE_FRAMES=4, FRAME_DIV=1 -> PLAY after 4th frame_end; ball_x 316->318 on next step.
- Ball x=12 moving left, pos_yBarra1=200, y=200 -> dx=+2, dy=-3 (top zone); y=240 centre zone with rnd[1]=0 -> |dy|=1, sign kept.
- Ball y=1, dy=-3 -> y=0 clamped, dy=+3; y=470, dy=+3 -> y=472, dy=-3.
- Ball passes missing paddle, x<=2 dx<0 -> point_evt=2'b01 for one cycle, score2=1, ball (316,236), state SERVE, serves left.
- score1=2, right goal -> score1=3, game_over=1, state OVER; restart pulse -> scores 0, SERVE.
- enablePong low mid-PLAY for 5 frames -> ball_x, counters unchanged, color 0; i_rst_n asserted mid-frame -> outputs at reset values immediately (async).
